// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared definitions for the processor-side bus cycle controller.
//   - bus_state_e  : bus cycle state encoding (IDLE, T1, TW, T2)
//   - DEF_WS_WIDTH : default width of one per-region wait-state field
package bus_ctrl_pkg;

  localparam int DEF_WS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    TW   = 2'd2,
    T2   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_region_pick.sv
// bus_region_pick: combinational region selection for a new bus cycle.
// Picks the lowest set bit of the decoder output as a one-hot select and
// muxes out that region's wait-state field and ext-ready mask bit.
// Ports:
//   region_sel [NUM_REGIONS]          in  : decoder output (may be multi-hot or zero)
//   ws_cfg     [NUM_REGIONS*WS_WIDTH] in  : per-region wait states, region i at [i*WS_WIDTH +: WS_WIDTH]
//   onehot     [NUM_REGIONS]          out : lowest set bit of region_sel, zero when none set
//   ws         [WS_WIDTH]             out : wait states of the picked region, zero when none set
//   ext_need                          out : picked region also waits for ext_rdy
//   hit                               out : at least one region selected
module bus_region_pick
  import bus_ctrl_pkg::*;
#(
  parameter int                     NUM_REGIONS  = 4,
  parameter int                     WS_WIDTH     = DEF_WS_WIDTH,
  parameter logic [NUM_REGIONS-1:0] EXT_RDY_MASK = {NUM_REGIONS{1'b0}}
) (
  input  logic [NUM_REGIONS-1:0]          region_sel,
  input  logic [NUM_REGIONS*WS_WIDTH-1:0] ws_cfg,
  output logic [NUM_REGIONS-1:0]          onehot,
  output logic [WS_WIDTH-1:0]             ws,
  output logic                            ext_need,
  output logic                            hit
);

  logic found_s;

  // Priority select: the first set bit scanning upward from region 0 wins.
  always_comb begin
    onehot   = {NUM_REGIONS{1'b0}};
    ws       = {WS_WIDTH{1'b0}};
    ext_need = 1'b0;
    found_s  = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region_sel[i] && !found_s) begin
        onehot[i] = 1'b1;
        ws        = ws_cfg[i*WS_WIDTH +: WS_WIDTH];
        ext_need  = EXT_RDY_MASK[i];
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  assign hit = |region_sel;

endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: processor-side bus cycle controller for the bridge.
// Accepts a CPU address strobe, latches region select and read/write,
// inserts per-region wait states, optionally waits for ext_rdy, and ends
// every cycle with a one-cycle active-low _ready.
// Optional build macro: BUS_CTRL_TIMEOUT_EN -- bounds ext_rdy waits to
// TIMEOUT_CYCLES wait cycles and flags bus_err when the bound expires.
// Ports:
//   clk, _rst (async, active low)
//   _ads, w_r, region_sel, ws_cfg, ext_rdy : CPU strobe / qualifiers / config / device ready
//   _ready      : cycle termination, active low, low in T2
//   bce, oe, we : buffer enable, read output enable, write strobe
//   cs          : registered one-hot chip select
//   unmapped    : one-cycle pulse in T1 when no region was selected
//   bus_err     : one-cycle pulse in T2 after an ext_rdy timeout
// All outputs decode registers only; no input reaches an output combinationally.
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int                     NUM_REGIONS    = 4,
  parameter int                     WS_WIDTH       = DEF_WS_WIDTH,
  parameter logic [NUM_REGIONS-1:0] EXT_RDY_MASK   = {NUM_REGIONS{1'b0}},
  parameter int                     TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            _rst,
  input  logic                            _ads,
  input  logic                            w_r,
  input  logic [NUM_REGIONS-1:0]          region_sel,
  input  logic [NUM_REGIONS*WS_WIDTH-1:0] ws_cfg,
  input  logic                            ext_rdy,
  output logic                            _ready,
  output logic                            bce,
  output logic                            oe,
  output logic                            we,
  output logic [NUM_REGIONS-1:0]          cs,
  output logic                            unmapped,
  output logic                            bus_err
);

  bus_state_e             state_r, state_n;
  logic [WS_WIDTH-1:0]    cnt_r, cnt_n;
  logic                   write_r, write_n;
  logic [NUM_REGIONS-1:0] cs_r, cs_n;
  logic                   ext_need_r, ext_need_n;
  logic                   unmapped_r, unmapped_n;

  logic [NUM_REGIONS-1:0] pick_onehot_s;
  logic [WS_WIDTH-1:0]    pick_ws_s;
  logic                   pick_ext_s;
  logic                   pick_hit_s;
  logic                   ext_ok_s;

`ifdef BUS_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_r, tmo_n;
  logic             bus_err_r, bus_err_n;
`endif

  bus_region_pick #(
    .NUM_REGIONS  (NUM_REGIONS),
    .WS_WIDTH     (WS_WIDTH),
    .EXT_RDY_MASK (EXT_RDY_MASK)
  ) u_pick (
    .region_sel (region_sel),
    .ws_cfg     (ws_cfg),
    .onehot     (pick_onehot_s),
    .ws         (pick_ws_s),
    .ext_need   (pick_ext_s),
    .hit        (pick_hit_s)
  );

  // Unmasked regions (and unmapped cycles) never wait on the device.
  assign ext_ok_s = !ext_need_r || ext_rdy;

  // Next-state and next-value logic for the bus cycle FSM.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    write_n    = write_r;
    cs_n       = cs_r;
    ext_need_n = ext_need_r;
    unmapped_n = 1'b0;
`ifdef BUS_CTRL_TIMEOUT_EN
    tmo_n      = tmo_r;
    bus_err_n  = 1'b0;
`endif
    case (state_r)
      // The strobe is honoured only here; T2 with _ads low chains directly into T1.
      IDLE, T2: begin
        if (!_ads) begin
          state_n    = T1;
          write_n    = w_r;
          cs_n       = pick_onehot_s;
          cnt_n      = pick_ws_s;
          ext_need_n = pick_ext_s;
          unmapped_n = !pick_hit_s;
`ifdef BUS_CTRL_TIMEOUT_EN
          tmo_n      = {TMO_W{1'b0}};
`endif
        end else begin
          state_n    = IDLE;
          write_n    = 1'b0;
          cs_n       = {NUM_REGIONS{1'b0}};
          cnt_n      = {WS_WIDTH{1'b0}};
          ext_need_n = 1'b0;
        end
      end
      // The first decrement happens on leaving T1 so that W wait states
      // put _ready low W+1 edges after T1 is entered.
      T1: begin
        if ((cnt_r == {WS_WIDTH{1'b0}}) && ext_ok_s) begin
          state_n = T2;
        end else begin
          state_n = TW;
          if (cnt_r != {WS_WIDTH{1'b0}}) begin
            cnt_n = cnt_r - WS_WIDTH'(1'b1);
          end else begin
            cnt_n = cnt_r;
          end
        end
      end
      // ext_rdy is looked at only once the programmed wait states are spent.
      TW: begin
        if (cnt_r != {WS_WIDTH{1'b0}}) begin
          cnt_n = cnt_r - WS_WIDTH'(1'b1);
        end else if (ext_ok_s) begin
          state_n = T2;
        end else begin
`ifdef BUS_CTRL_TIMEOUT_EN
          if (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_n   = T2;
            bus_err_n = 1'b1;
          end else begin
            tmo_n     = tmo_r + TMO_W'(1'b1);
          end
`else
          state_n = TW;
`endif
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and cycle-attribute registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_r    <= IDLE;
      cnt_r      <= {WS_WIDTH{1'b0}};
      write_r    <= 1'b0;
      cs_r       <= {NUM_REGIONS{1'b0}};
      ext_need_r <= 1'b0;
      unmapped_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      write_r    <= write_n;
      cs_r       <= cs_n;
      ext_need_r <= ext_need_n;
      unmapped_r <= unmapped_n;
    end
  end

`ifdef BUS_CTRL_TIMEOUT_EN
  // Timeout counter and its error pulse.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      tmo_r     <= {TMO_W{1'b0}};
      bus_err_r <= 1'b0;
    end else begin
      tmo_r     <= tmo_n;
      bus_err_r <= bus_err_n;
    end
  end

  assign bus_err = bus_err_r;
`else
  // TIMEOUT_CYCLES is non-negative, so this is constant 0.
  assign bus_err = (TIMEOUT_CYCLES < 0);
`endif

  // An unmapped cycle has cs_r == 0, which keeps oe/we low for it.
  assign _ready   = (state_r != T2);
  assign bce      = (state_r != IDLE);
  assign oe       = !write_r && (|cs_r) && ((state_r == TW) || (state_r == T2));
  assign we       =  write_r && (|cs_r) && ((state_r == TW) || (state_r == T2));
  assign cs       = cs_r;
  assign unmapped = unmapped_r;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed self-checking bench for bus_cycle_ctrl.
// Region 1 is ext-ready masked; ws_cfg = {r3=2, r2=3, r1=1, r0=0}.
module tb_bus_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ads_n;
  logic       w_r;
  logic [3:0] region_sel;
  logic [15:0] ws_cfg;
  logic       ext_rdy;
  logic       ready_n;
  logic       bce;
  logic       oe;
  logic       we;
  logic [3:0] cs;
  logic       unmapped;
  logic       bus_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_cycle_ctrl #(
    .NUM_REGIONS    (4),
    .WS_WIDTH       (4),
    .EXT_RDY_MASK   (4'b0010),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    ._rst       (rst_n),
    ._ads       (ads_n),
    .w_r        (w_r),
    .region_sel (region_sel),
    .ws_cfg     (ws_cfg),
    .ext_rdy    (ext_rdy),
    ._ready     (ready_n),
    .bce        (bce),
    .oe         (oe),
    .we         (we),
    .cs         (cs),
    .unmapped   (unmapped),
    .bus_err    (bus_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b1;
    ads_n      = 1'b1;
    w_r        = 1'b0;
    region_sel = 4'b0000;
    ws_cfg     = 16'h2310;
    ext_rdy    = 1'b0;
    #2 rst_n   = 1'b0;
    tick();
    tick();
    check_eq("rst_ready", 32'(ready_n), 32'd1);
    check_eq("rst_bce", 32'(bce), 32'd0);
    check_eq("rst_oe", 32'(oe), 32'd0);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_cs", 32'(cs), 32'd0);
    check_eq("rst_unmapped", 32'(unmapped), 32'd0);
    check_eq("rst_bus_err", 32'(bus_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_ready", 32'(ready_n), 32'd1);

    // Read, region 0, no wait states.
    region_sel = 4'b0001; w_r = 1'b0; ads_n = 1'b0;
    tick();
    ads_n = 1'b1;
    check_eq("r0_t1_ready", 32'(ready_n), 32'd1);
    check_eq("r0_t1_bce", 32'(bce), 32'd1);
    check_eq("r0_t1_oe", 32'(oe), 32'd0);
    check_eq("r0_t1_cs", 32'(cs), 32'h1);
    tick();
    check_eq("r0_t2_ready", 32'(ready_n), 32'd0);
    check_eq("r0_t2_oe", 32'(oe), 32'd1);
    check_eq("r0_t2_cs", 32'(cs), 32'h1);
    tick();
    check_eq("r0_idle_ready", 32'(ready_n), 32'd1);
    check_eq("r0_idle_bce", 32'(bce), 32'd0);
    check_eq("r0_idle_oe", 32'(oe), 32'd0);
    check_eq("r0_idle_cs", 32'(cs), 32'h0);

    // Write, region 2, three wait states.
    region_sel = 4'b0100; w_r = 1'b1; ads_n = 1'b0;
    tick();
    ads_n = 1'b1;
    check_eq("w2_t1_we", 32'(we), 32'd0);
    check_eq("w2_t1_cs", 32'(cs), 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("w2_tw_ready", 32'(ready_n), 32'd1);
      check_eq("w2_tw_we", 32'(we), 32'd1);
      check_eq("w2_tw_oe", 32'(oe), 32'd0);
    end
    tick();
    check_eq("w2_t2_ready", 32'(ready_n), 32'd0);
    check_eq("w2_t2_we", 32'(we), 32'd1);
    tick();
    check_eq("w2_idle_ready", 32'(ready_n), 32'd1);
    check_eq("w2_idle_we", 32'(we), 32'd0);

    // Read, region 1 (ext masked, ws=1); early ext_rdy must be ignored.
    region_sel = 4'b0010; w_r = 1'b0; ads_n = 1'b0;
    tick();
    ads_n = 1'b1; ext_rdy = 1'b1;
    tick();
    ext_rdy = 1'b0;
    check_eq("x1_tw_ready", 32'(ready_n), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("x1_wait_ready", 32'(ready_n), 32'd1);
      check_eq("x1_wait_oe", 32'(oe), 32'd1);
    end
    ext_rdy = 1'b1;
    tick();
    ext_rdy = 1'b0;
    check_eq("x1_t2_ready", 32'(ready_n), 32'd0);
    check_eq("x1_t2_bus_err", 32'(bus_err), 32'd0);
    tick();
    check_eq("x1_idle_bce", 32'(bce), 32'd0);

    // Unmapped read.
    region_sel = 4'b0000; w_r = 1'b0; ads_n = 1'b0;
    tick();
    ads_n = 1'b1;
    check_eq("um_t1_unmapped", 32'(unmapped), 32'd1);
    check_eq("um_t1_cs", 32'(cs), 32'h0);
    check_eq("um_t1_bce", 32'(bce), 32'd1);
    tick();
    check_eq("um_t2_ready", 32'(ready_n), 32'd0);
    check_eq("um_t2_unmapped", 32'(unmapped), 32'd0);
    check_eq("um_t2_oe", 32'(oe), 32'd0);
    check_eq("um_t2_we", 32'(we), 32'd0);
    tick();
    check_eq("um_idle_ready", 32'(ready_n), 32'd1);

    // Back-to-back: read r0, then write with region_sel 0110 -> cs 0010.
    region_sel = 4'b0001; w_r = 1'b0; ads_n = 1'b0;
    tick();
    region_sel = 4'b0110; w_r = 1'b1; ext_rdy = 1'b1;
    tick();
    check_eq("bb_t2_ready", 32'(ready_n), 32'd0);
    check_eq("bb_t2_cs", 32'(cs), 32'h1);
    tick();
    ads_n = 1'b1;
    check_eq("bb_t1_ready", 32'(ready_n), 32'd1);
    check_eq("bb_t1_bce", 32'(bce), 32'd1);
    check_eq("bb_t1_cs", 32'(cs), 32'h2);
    check_eq("bb_t1_we", 32'(we), 32'd0);
    tick();
    check_eq("bb_tw_we", 32'(we), 32'd1);
    check_eq("bb_tw_ready", 32'(ready_n), 32'd1);
    tick();
    check_eq("bb_t2b_ready", 32'(ready_n), 32'd0);
    check_eq("bb_t2b_cs", 32'(cs), 32'h2);
    ext_rdy = 1'b0;
    tick();
    check_eq("bb_idle_bce", 32'(bce), 32'd0);

    // ws_cfg change after T1 entry has no effect (region 3, ws=2).
    region_sel = 4'b1000; w_r = 1'b0; ads_n = 1'b0;
    tick();
    ads_n = 1'b1; ws_cfg = 16'hF310;
    tick();
    check_eq("cfg_tw1_ready", 32'(ready_n), 32'd1);
    tick();
    check_eq("cfg_tw2_ready", 32'(ready_n), 32'd1);
    tick();
    check_eq("cfg_t2_ready", 32'(ready_n), 32'd0);
    check_eq("cfg_t2_cs", 32'(cs), 32'h8);
    ws_cfg = 16'h2310;
    tick();

    // Asynchronous reset during TW, then a clean cycle.
    region_sel = 4'b0100; w_r = 1'b1; ads_n = 1'b0;
    tick();
    ads_n = 1'b1;
    tick();
    check_eq("ar_tw_we", 32'(we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_ready", 32'(ready_n), 32'd1);
    check_eq("ar_bce", 32'(bce), 32'd0);
    check_eq("ar_we", 32'(we), 32'd0);
    check_eq("ar_cs", 32'(cs), 32'h0);
    #1 rst_n = 1'b1;
    region_sel = 4'b0001; w_r = 1'b0; ads_n = 1'b0;
    tick();
    ads_n = 1'b1;
    check_eq("ar_t1_cs", 32'(cs), 32'h1);
    check_eq("ar_t1_we", 32'(we), 32'd0);
    tick();
    check_eq("ar_t2_ready", 32'(ready_n), 32'd0);
    check_eq("ar_t2_oe", 32'(oe), 32'd1);
    tick();
    check_eq("ar_idle_ready", 32'(ready_n), 32'd1);

`ifdef BUS_CTRL_TIMEOUT_EN
    // Region 1 with ext_rdy stuck low: timeout after 8 wait cycles.
    region_sel = 4'b0010; w_r = 1'b0; ads_n = 1'b0;
    tick();
    ads_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("to_wait_ready", 32'(ready_n), 32'd1);
      check_eq("to_wait_bus_err", 32'(bus_err), 32'd0);
    end
    tick();
    check_eq("to_t2_ready", 32'(ready_n), 32'd0);
    check_eq("to_t2_bus_err", 32'(bus_err), 32'd1);
    check_eq("to_t2_oe", 32'(oe), 32'd1);
    tick();
    check_eq("to_idle_bus_err", 32'(bus_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
